// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM built-in self-test controller: FSM state
// type and the data pattern written to / expected from each address.
package ram_bist_pkg;

   // Working width for the pattern helper; callers truncate to their DW,
   // which gives the modulo-2**DW wrap for free.
   localparam int PAT_W = 32;

   // Largest supported RAM read latency.
   localparam int MAX_READ_LAT = 4;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   // Data written to an address and expected back from it.
   function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                                input logic [PAT_W-1:0] offset);
      return addr + offset;
   endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// Single RAM port as seen by a requester (master) and by the RAM (slave).
interface ram_bist_ctrl_if #(
   parameter int AW = 2,
   parameter int DW = 4
);

   logic          ram_en;
   logic          ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport master (
      output ram_en,
      output ram_wr,
      output ram_addr,
      output ram_din,
      input  ram_dout
   );

   modport slave (
      input  ram_en,
      input  ram_wr,
      input  ram_addr,
      input  ram_din,
      output ram_dout
   );

endinterface

// File: rtl/ram_bist_chk.sv
// Read-back checker: delays {valid, addr, expected} by the RAM read latency,
// compares against the returned data and keeps the error count and the
// address of the first mismatch of the run.
module ram_bist_chk
   import ram_bist_pkg::*;
#(
   parameter int          AW       = 2,
   parameter int          DW       = 4,
   parameter int unsigned READ_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] exp,
   input  logic [DW-1:0] ram_dout,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] first_err_addr
);

   // Saturation point: every address of the RAM mismatched.
   localparam logic [AW:0] ERR_MAX = {1'b1, {AW{1'b0}}};

   logic          pv [READ_LAT];
   logic [AW-1:0] pa [READ_LAT];
   logic [DW-1:0] pe [READ_LAT];
   logic          mismatch;

   // Shift pipeline aligning each issued read with its returning data.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int unsigned i = 0; i < READ_LAT; i++) begin
            pv[i] <= 1'b0;
            pa[i] <= '0;
            pe[i] <= '0;
         end
      end else begin
         pv[0] <= push;
         pa[0] <= addr;
         pe[0] <= exp;
         for (int unsigned i = 1; i < READ_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
         end
      end
   end

   // Compare the pipeline head with the data the RAM is returning now.
   always_comb begin
      mismatch = pv[READ_LAT-1] && (ram_dout != pe[READ_LAT-1]);
   end

   // Error counter (saturating) and first-failing-address capture.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (mismatch) begin
         if (err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
         end
         if (err_count == '0) begin
            first_err_addr <= pa[READ_LAT-1];
         end
      end
   end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM self-test initiator: writes (addr + offset) to every location, reads
// everything back, waits for the last read data and reports pass/fail with
// mismatch count and first failing address. All outputs decode from state.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int          AW       = 2,
   parameter int          DW       = 4,
   parameter int unsigned READ_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DW-1:0]   offset,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [AW:0]     err_count,
   output logic [AW-1:0]   first_err_addr,
   ram_bist_ctrl_if.master ram
);

   localparam logic [2:0] DRAIN_LAST = 3'(READ_LAT - 1);

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_n;
   logic [2:0]    drain_cnt;
   logic [2:0]    drain_n;
   logic [DW-1:0] offset_q;
   logic [DW-1:0] offset_n;
   logic          clr;
   logic          push;
   logic [DW-1:0] exp_data;

   // Pattern for the current address under the latched offset.
   always_comb begin
      exp_data = DW'(pattern(PAT_W'(cnt), PAT_W'(offset_q)));
   end

   // State, address counter, drain counter and latched offset registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         drain_cnt <= '0;
         offset_q  <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         drain_cnt <= drain_n;
         offset_q  <= offset_n;
      end
   end

   // Next-state logic; start is only honoured from IDLE or DONE.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      drain_n  = drain_cnt;
      offset_n = offset_q;
      clr      = 1'b0;
      push     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               offset_n = offset;
               clr      = 1'b1;
               cnt_n    = '0;
               state_n  = WRITE;
            end
         end
         WRITE: begin
            cnt_n = cnt + 1'b1;
            if (cnt == '1) begin
               state_n = READ;
            end
         end
         READ: begin
            push  = 1'b1;
            cnt_n = cnt + 1'b1;
            if (cnt == '1) begin
               drain_n = '0;
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            drain_n = drain_cnt + 1'b1;
            if (drain_cnt == DRAIN_LAST) begin
               state_n = DONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output decode from registered state; no path from start or ram_dout.
   always_comb begin
      busy = (state == WRITE) || (state == READ) || (state == DRAIN);
      done = (state == DONE);
      pass = done && (err_count == '0);
   end

   assign ram.ram_en   = (state == WRITE) || (state == READ);
   assign ram.ram_wr   = (state == WRITE);
   assign ram.ram_addr = cnt;
   assign ram.ram_din  = (state == WRITE) ? exp_data : '0;

   ram_bist_chk #(
      .AW       (AW),
      .DW       (DW),
      .READ_LAT (READ_LAT)
   ) u_chk (
      .clk            (clk),
      .rst            (rst),
      .clr            (clr),
      .push           (push),
      .addr           (cnt),
      .exp            (exp_data),
      .ram_dout       (ram.ram_dout),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (read latency 1 and 2), each with a
// behavioural RAM that can inject faults, a cycle-indexed reference model and
// a per-cycle compare process, plus hand-computed literal checks.
module tb_ram_bist_ctrl;

   localparam int          AW      = 2;
   localparam int          DW      = 4;
   localparam int          DEPTH   = 4;
   localparam int          PB_ADDR = 1;
   localparam logic [3:0]  PB_VAL  = 4'hA;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_r   [2];
   logic          start_r [2];
   logic [DW-1:0] off_r   [2];
   int            fmode   [2];  // 0 none, 1 flip bit0 @2, 2 dout=0, 3 port-B write
   logic          pb_we   [2];

   logic          busy_w  [2];
   logic          done_w  [2];
   logic          pass_w  [2];
   logic [AW:0]   err_w   [2];
   logic [AW-1:0] first_w [2];
   logic          en_w    [2];
   logic          wr_w    [2];
   logic [AW-1:0] addr_w  [2];
   logic [DW-1:0] din_w   [2];

   int n_vec = 0;
   int n_bad = 0;
   int cur   = 0;
   bit armed = 1'b0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_inst
         localparam int RL = gi + 1;

         ram_bist_ctrl_if #(.AW(AW), .DW(DW)) rif ();

         ram_bist_ctrl #(.AW(AW), .DW(DW), .READ_LAT(RL)) dut (
            .clk            (clk),
            .rst            (rst_r[gi]),
            .start          (start_r[gi]),
            .offset         (off_r[gi]),
            .busy           (busy_w[gi]),
            .done           (done_w[gi]),
            .pass           (pass_w[gi]),
            .err_count      (err_w[gi]),
            .first_err_addr (first_w[gi]),
            .ram            (rif)
         );

         logic [DW-1:0] mem [DEPTH];
         logic [DW-1:0] pd  [RL];
         logic [AW-1:0] pa  [RL];

         // RAM model with RL-cycle read latency and a second write port.
         always @(posedge clk) begin
            if (rif.ram_en && rif.ram_wr) mem[rif.ram_addr] <= rif.ram_din;
            if (pb_we[gi]) mem[PB_ADDR] <= PB_VAL;
            pd[0] <= mem[rif.ram_addr];
            pa[0] <= rif.ram_addr;
            for (int k = 1; k < RL; k++) begin
               pd[k] <= pd[k-1];
               pa[k] <= pa[k-1];
            end
         end

         assign rif.ram_dout = (fmode[gi] == 2) ? '0 :
                               pd[RL-1] ^ (((fmode[gi] == 1) && (pa[RL-1] == 2'd2)) ? 4'h1 : 4'h0);

         assign en_w[gi]   = rif.ram_en;
         assign wr_w[gi]   = rif.ram_wr;
         assign addr_w[gi] = rif.ram_addr;
         assign din_w[gi]  = rif.ram_din;
      end
   endgenerate

   // ---------------- reference model ----------------
   int mact [2];
   int mt   [2];
   int moff [2];
   int merr [2];
   int mfst [2];

   function automatic int t_done(input int i);
      return 2 * DEPTH + (i + 1) + 1;
   endfunction

   // Expected mismatches for a whole run from the fault mode and offset.
   task automatic predict(input int mode, input int off, output int cnt, output int first);
      int pat, r;
      cnt = 0;
      first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         pat = (a + off) % 16;
         r = pat;
         if (mode == 1 && a == 2) r = pat ^ 1;
         if (mode == 2) r = 0;
         if (mode == 3 && a == PB_ADDR) r = PB_VAL;
         if (r != pat) begin
            if (cnt == 0) first = a;
            cnt++;
         end
      end
   endtask

   always @(posedge clk) begin : model
      int c, f;
      for (int i = 0; i < 2; i++) begin
         if (rst_r[i]) begin
            mact[i] <= 0;
            mt[i]   <= 0;
            merr[i] <= 0;
            mfst[i] <= 0;
         end else if (start_r[i] && (mact[i] == 0 || mt[i] == t_done(i))) begin
            predict(fmode[i], int'(off_r[i]), c, f);
            mact[i] <= 1;
            mt[i]   <= 1;
            moff[i] <= int'(off_r[i]);
            merr[i] <= c;
            mfst[i] <= f;
         end else if (mact[i] != 0 && mt[i] < t_done(i)) begin
            mt[i] <= mt[i] + 1;
         end
      end
   end

   task automatic chk(input string name, input int i, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, i, $time, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            int t, td;
            t  = mt[i];
            td = t_done(i);
            if (mact[i] == 0) begin
               chk("idle_busy", i, busy_w[i], 0);
               chk("idle_done", i, done_w[i], 0);
               chk("idle_pass", i, pass_w[i], 0);
               chk("idle_en",   i, en_w[i],   0);
               chk("idle_wr",   i, wr_w[i],   0);
               chk("idle_addr", i, addr_w[i], 0);
               chk("idle_din",  i, din_w[i],  0);
               chk("idle_err",  i, err_w[i],  0);
               chk("idle_first", i, first_w[i], 0);
            end else begin
               chk("busy", i, busy_w[i], (t < td) ? 1 : 0);
               chk("done", i, done_w[i], (t == td) ? 1 : 0);
               chk("en",   i, en_w[i],   (t <= 2 * DEPTH) ? 1 : 0);
               chk("wr",   i, wr_w[i],   (t <= DEPTH) ? 1 : 0);
               if (t <= 2 * DEPTH) begin
                  chk("addr", i, addr_w[i], (t - 1) % DEPTH);
                  chk("din",  i, din_w[i],  (t <= DEPTH) ? (t - 1 + moff[i]) % 16 : 0);
               end
               if (t == td) begin
                  chk("err",   i, err_w[i],   merr[i]);
                  chk("first", i, first_w[i], mfst[i]);
                  chk("pass",  i, pass_w[i],  (merr[i] == 0) ? 1 : 0);
               end
               if (t == 1) begin
                  chk("clr_err",   i, err_w[i],   0);
                  chk("clr_first", i, first_w[i], 0);
                  chk("clr_pass",  i, pass_w[i],  0);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_run(input int i, input logic [3:0] off, input int mode);
      @(posedge clk);
      #1;
      fmode[i]   = mode;
      off_r[i]   = off;
      start_r[i] = 1'b1;
      @(posedge clk);
      #1;
      start_r[i] = 1'b0;
      cur = 1;
   endtask

   // Move to cycle k of the current run (1 ns after its opening edge).
   task automatic go(input int k);
      repeat (k - cur) @(posedge clk);
      #1;
      cur = k;
   endtask

   // Move to cycle k and wait for its sampling edge.
   task automatic at(input int k);
      go(k);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_r[i]   = 1'b1;
         start_r[i] = 1'b0;
         off_r[i]   = '0;
         fmode[i]   = 0;
         pb_we[i]   = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_r[0] = 1'b0;
      rst_r[1] = 1'b0;
      armed = 1'b1;
      @(negedge clk);
      chk("lit_rst_busy", 0, busy_w[0], 0);
      chk("lit_rst_en",   0, en_w[0],   0);
      chk("lit_rst_done", 0, done_w[0], 0);

      // offset 0: data 0,1,2,3
      start_run(0, 4'h0, 0);
      at(2);  chk("lit_a_din_c2", 0, din_w[0], 1);
      at(9);  chk("lit_a_done_c9", 0, done_w[0], 0);
      at(10); chk("lit_a_done_c10", 0, done_w[0], 1);
              chk("lit_a_pass", 0, pass_w[0], 1);
              chk("lit_a_err", 0, err_w[0], 0);

      // offset E: data E,F,0,1
      start_run(0, 4'hE, 0);
      at(3);  chk("lit_b_din_c3", 0, din_w[0], 0);
      at(4);  chk("lit_b_din_c4", 0, din_w[0], 1);
      at(10); chk("lit_b_pass", 0, pass_w[0], 1);

      // restart straight from DONE, offset 3
      start_run(0, 4'h3, 0);
      at(1);  chk("lit_c_din_c1", 0, din_w[0], 3);
      at(10); chk("lit_c_pass", 0, pass_w[0], 1);

      // bit 0 corrupted on readback of address 2
      start_run(0, 4'h0, 1);
      at(10); chk("lit_d_err", 0, err_w[0], 1);
              chk("lit_d_first", 0, first_w[0], 2);
              chk("lit_d_pass", 0, pass_w[0], 0);

      // dout stuck at 0, offset 5
      start_run(0, 4'h5, 2);
      at(10); chk("lit_e_err", 0, err_w[0], 4);
              chk("lit_e_first", 0, first_w[0], 0);

      // start pulses in cycles 3 and 6 are ignored
      start_run(0, 4'h3, 0);
      go(3); start_r[0] = 1'b1;
      go(4); start_r[0] = 1'b0;
      go(6); start_r[0] = 1'b1;
      go(7); start_r[0] = 1'b0;
      at(7);  chk("lit_f_addr_c7", 0, addr_w[0], 2);
      at(9);  chk("lit_f_done_c9", 0, done_w[0], 0);
      at(10); chk("lit_f_done_c10", 0, done_w[0], 1);
              chk("lit_f_pass", 0, pass_w[0], 1);

      // second port overwrites address 1 during READ
      start_run(0, 4'h0, 3);
      go(5); pb_we[0] = 1'b1;
      go(6); pb_we[0] = 1'b0;
      at(10); chk("lit_g_err", 0, err_w[0], 1);
              chk("lit_g_first", 0, first_w[0], 1);

      // reset during cycle 2 of WRITE
      start_run(0, 4'h0, 0);
      go(2); rst_r[0] = 1'b1;
      go(3); rst_r[0] = 1'b0;
      at(3);  chk("lit_h_en", 0, en_w[0], 0);
              chk("lit_h_busy", 0, busy_w[0], 0);
              chk("lit_h_addr", 0, addr_w[0], 0);

      // read latency 2 instance
      start_run(1, 4'h7, 0);
      at(10); chk("lit_i_done_c10", 1, done_w[1], 0);
      at(11); chk("lit_i_done_c11", 1, done_w[1], 1);
              chk("lit_i_pass", 1, pass_w[1], 1);
      start_run(1, 4'h0, 1);
      at(11); chk("lit_j_err", 1, err_w[1], 1);
              chk("lit_j_first", 1, first_w[1], 2);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
